// File: rtl/matmul_ctrl.sv
// 2x2 signed matrix multiply sequencer: loads A and B from the matrix memory,
// computes C = A x B with one shared multiplier and writes saturated C back.
module matmul_ctrl #(
  parameter int DW = 18,
  parameter int N  = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [DW-1:0] mem_out,
  output logic [1:0]    addr,
  output logic [1:0]    sel,
  output logic          wr,
  output logic [DW-1:0] mem_in,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int NE = N * N;
  localparam int AW = 2 * DW + 1;
  localparam int PW = 2 * DW;

  localparam logic signed [AW-1:0] ACC_MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MUL0,
    MUL1,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [1:0] e_q, e_d;
  logic [DW-1:0] a_q [NE];
  logic [DW-1:0] a_d [NE];
  logic [DW-1:0] b_q [NE];
  logic [DW-1:0] b_d [NE];
  logic signed [AW-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;

  logic                 col;
  logic [DW-1:0]        op_a, op_b;
  logic signed [PW-1:0] ext_a, ext_b, prod;
  logic [DW-1:0]        sat_val;
  logic                 sat_hit;

  // Single multiplier: MUL0 uses column/row 0 of the inner dimension, MUL1 uses 1.
  always_comb begin
    col   = (state_q == MUL1);
    op_a  = a_q[{e_q[1], col}];
    op_b  = b_q[{col, e_q[0]}];
    ext_a = {{DW{op_a[DW-1]}}, op_a};
    ext_b = {{DW{op_b[DW-1]}}, op_b};
    prod  = ext_a * ext_b;
  end

  always_comb begin
    sat_hit = 1'b1;
    if (acc_q > ACC_MAX) begin
      sat_val = SAT_MAX;
    end else if (acc_q < ACC_MIN) begin
      sat_val = SAT_MIN;
    end else begin
      sat_val = acc_q[DW-1:0];
      sat_hit = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    e_d     = e_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    addr    = '0;
    sel     = 2'b00;
    wr      = 1'b0;
    mem_in  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          k_d     = '0;
          e_d     = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD_A: begin
        busy      = 1'b1;
        sel       = 2'b00;
        addr      = k_q;
        a_d[k_q]  = mem_out;
        k_d       = k_q + 2'd1;
        if (k_q == 2'd3) state_d = LOAD_B;
      end
      LOAD_B: begin
        busy      = 1'b1;
        sel       = 2'b01;
        addr      = k_q;
        b_d[k_q]  = mem_out;
        k_d       = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = MUL0;
          e_d     = '0;
        end
      end
      MUL0: begin
        busy    = 1'b1;
        acc_d   = AW'(prod);
        state_d = MUL1;
      end
      MUL1: begin
        busy    = 1'b1;
        acc_d   = acc_q + AW'(prod);
        state_d = WRITE;
      end
      WRITE: begin
        busy   = 1'b1;
        sel    = 2'b11;
        addr   = e_q;
        wr     = 1'b1;
        mem_in = sat_val;
        if (sat_hit) ovf_d = 1'b1;
        if (e_q == 2'd3) begin
          state_d = DONE;
        end else begin
          e_d     = e_q + 2'd1;
          state_d = MUL0;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      k_q     <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < NE; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl: behavioural matrix memory, expected
// writes queued at start and checked as the DUT writes them.
module tb_matmul_ctrl;

  localparam int DW = 18;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 start;
  logic signed [DW-1:0] mem_out;
  logic [1:0]           addr;
  logic [1:0]           sel;
  logic                 wr;
  logic signed [DW-1:0] mem_in;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  matmul_ctrl #(.DW(DW), .N(2)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .mem_out (mem_out),
    .addr    (addr),
    .sel     (sel),
    .wr      (wr),
    .mem_in  (mem_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem_a [4];
  logic signed [DW-1:0] mem_b [4];
  logic signed [DW-1:0] mem_c [4];
  longint mat_a [4];
  longint mat_b [4];

  always_comb begin
    case (sel)
      2'b00:   mem_out = mem_a[addr];
      2'b01:   mem_out = mem_b[addr];
      2'b11:   mem_out = mem_c[addr];
      default: mem_out = '0;
    endcase
  end

  always @(posedge clk) begin
    if (wr) mem_c[addr] <= mem_in;
  end

  typedef struct {
    logic [1:0] addr;
    longint     data;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("sb_has_entry", 0, 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", longint'(addr), longint'(e.addr));
        check("wr_data", longint'(mem_in), e.data);
      end
    end
    if (done) done_cnt++;
  end

  // Loads memory from mat_a/mat_b and queues the expected writes; returns model ovf.
  task automatic prepare(output longint exp_ovf);
    exp_ovf = 0;
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = DW'(mat_a[k]);
      mem_b[k] = DW'(mat_b[k]);
    end
    for (int e = 0; e < 4; e++) begin
      int     i;
      int     j;
      longint s;
      exp_t   x;
      i = e / 2;
      j = e % 2;
      s = mat_a[i*2] * mat_b[j] + mat_a[i*2+1] * mat_b[2+j];
      if (s > 131071) begin
        s = 131071;
        exp_ovf = 1;
      end else if (s < -131072) begin
        s = -131072;
        exp_ovf = 1;
      end
      x.addr = 2'(e);
      x.data = s;
      sb.push_back(x);
    end
  endtask

  task automatic set_mats(input longint a0, a1, a2, a3, b0, b1, b2, b3);
    mat_a[0] = a0; mat_a[1] = a1; mat_a[2] = a2; mat_a[3] = a3;
    mat_b[0] = b0; mat_b[1] = b1; mat_b[2] = b2; mat_b[3] = b3;
  endtask

  task automatic run_op(input bit poke);
    longint exp_ovf;
    int     cyc;
    bit     got;
    prepare(exp_ovf);
    wr_cnt   = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    got   = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 3 || cyc == 15);
      if (cyc == 1) begin
        check("busy_after_start", longint'(busy), 1);
        check("ovf_cleared", longint'(ovf), 0);
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_latency", cyc, 21);
    check("busy_in_done", longint'(busy), 0);
    check("ovf_at_done", longint'(ovf), exp_ovf);
    @(negedge clk);
    check("done_one_cycle", longint'(done), 0);
    check("idle_not_busy", longint'(busy), 0);
    repeat (6) @(negedge clk);
    check("wr_count", wr_cnt, 4);
    check("done_count", done_cnt, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    longint dummy;
    nrst  = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_wr", longint'(wr), 0);
    check("rst_addr", longint'(addr), 0);
    check("rst_sel", longint'(sel), 0);
    check("rst_mem_in", longint'(mem_in), 0);
    check("rst_ovf", longint'(ovf), 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_op(1'b0);

    set_mats(-1, 0, 0, -1, 5, -6, 7, 8);
    run_op(1'b0);

    set_mats(131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071);
    run_op(1'b0);

    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_op(1'b0);

    set_mats(-131072, -131072, -131072, -131072, 131071, 131071, 131071, 131071);
    run_op(1'b0);

    set_mats(2, -3, 4, 5, -6, 7, 8, 9);
    run_op(1'b1);

    // Mid-run reset: outputs must collapse as soon as nrst falls.
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    prepare(dummy);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    check("arst_wr", longint'(wr), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check("arst_sel", longint'(sel), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_idle_busy", longint'(busy), 0);
    run_op(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
- Sequencer that drives the matrix memory's port as initiator. It reads the 2x2 operand matrices A (sel=00) and B (sel=01), computes C = A x B with a single shared multiplier, and writes C into the result region (sel=11).
- Sits between the top-level control logic and the matrix memory. It owns addr/sel/wr/mem_in while busy.

Parameters:
- DW, 18, element width; signed two's complement
- N, 2, matrix dimension; only 2 is supported, addr = row*N + col

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  reset
- start  input  1  request a multiply; sampled only in IDLE
- mem_out  input  DW  read data from memory; combinational w.r.t. addr/sel (same-cycle)
- addr  output  2  element address, row*2+col
- sel  output  2  region select: 00=A, 01=B, 11=result
- wr  output  1  write strobe to memory
- mem_in  output  DW  write data to memory
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  one-cycle pulse when all four results are written
- ovf  output  1  sticky; set if any result element saturated; cleared when start is accepted

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While nrst=0, all state is cleared.
- Reset values: state=IDLE, addr=0, sel=00, wr=0, mem_in=0, busy=0, done=0, ovf=0, local A/B regs=0, acc=0.
- Reset mid-operation: the FSM aborts immediately to IDLE and wr drops asynchronously. Partially written results remain in memory; they are not rolled back.
- States: IDLE, LOAD_A, LOAD_B, MUL0, MUL1, WRITE, DONE.
- IDLE: addr=0, sel=00, wr=0. start=1 at an edge moves to LOAD_A, clears ovf and clears index counters.
- LOAD_A: 4 cycles, k=0..3. Drives sel=00, addr=k and captures mem_out into a_reg[k] at each edge. After k=3, go to LOAD_B.
- LOAD_B: same as LOAD_A with sel=01 into b_reg[k]. Then go to MUL0 with element index e=0.
- Element e maps to i=e[1], j=e[0].
- MUL0: acc <= a[i][0]*b[0][j], a full 2*DW-bit signed product; the accumulator is 2*DW+1 bits.
- MUL1: acc <= acc + a[i][1]*b[1][j].
- WRITE: sel=11, addr=e, wr=1, mem_in=sat(acc).
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1], i.e. [-131072, 131071] for DW=18.
  - If clamping occurs, set ovf.
  - If e=3, go to DONE; else e<=e+1 and go to MUL0.
- wr is high only in WRITE. In all other states mem_in=0.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy=1 in LOAD_A through WRITE.
- start while busy or in DONE: ignored, with no queuing.
- start held high continuously: a new operation begins on the edge after DONE returns to IDLE. That means one IDLE cycle between runs.
- Latency: start accepted at edge 0 → LOAD_A cycles 1–4, LOAD_B 5–8, MUL0/MUL1/WRITE 9–20 (3 cycles per element), done high in cycle 21, IDLE in cycle 22.
- Operand capture is complete before any write. Therefore results never alias operands, even if the memory contents change during the compute phase.

Test Plan:
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start.
  - Result region = [19,22,43,50], written at addr 0..3 in order.
  - done pulses exactly 21 cycles after start is accepted; ovf=0.
- Signed operands: A=[[-1,0],[0,-1]], B=[[5,-6],[7,8]] → result = [-5,6,-7,-8]; ovf=0.
- Saturation:
  - All A=131071, all B=131071 → every result is 131071 and ovf=1.
  - Then rerun with the basic-multiply matrices → ovf clears on start and stays 0.
- Negative saturation: A all -131072, B all 131071 → every result is -131072; ovf=1.
- start while busy: pulse start at cycles 3 and 15 → only one done pulse, no extra writes; wr asserted exactly 4 cycles total.
- Async reset mid-run: drop nrst during cycle 12 (MUL/WRITE phase).
  - wr, busy and done go 0 immediately; state is IDLE.
  - A fresh start after release completes correctly in 21 cycles.
